// File: rtl/etroc2_frame_pkg.sv
// Shared constants for the ETROC2 frame parser: word markers, field positions, CRC polynomial.
package etroc2_frame_pkg;

  localparam logic [15:0] HEADER_MARK = 16'h3C5C;
  localparam logic [1:0]  HDR_TYPE    = 2'b00;
  localparam logic [1:0]  FILLER_TYPE = 2'b10;

  localparam int MARK_HI = 39;
  localparam int MARK_LO = 24;
  localparam int TYPE_HI = 23;
  localparam int TYPE_LO = 22;
  localparam int L1_HI   = 21;
  localparam int L1_LO   = 14;
  localparam int BCID_HI = 11;
  localparam int BCID_LO = 0;
  localparam int PIX_HI  = 36;
  localparam int PIX_LO  = 29;
  localparam int TDC_HI  = 28;
  localparam int TDC_LO  = 0;
  localparam int CHIP_HI = 38;
  localparam int CHIP_LO = 22;
  localparam int HITS_HI = 15;
  localparam int HITS_LO = 8;
  localparam int CRC_HI  = 7;
  localparam int CRC_LO  = 0;

  localparam logic [7:0] CRC8_POLY = 8'h97;

  typedef enum logic {IDLE, IN_FRAME} frame_state_t;

endpackage

// File: rtl/etroc2_crc8_40b.sv
// Combinational next-CRC-8 (MSB first) over a W-bit word; only built with ETROC2_FRAME_CRC_EN.
`ifdef ETROC2_FRAME_CRC_EN
module etroc2_crc8_40b
  import etroc2_frame_pkg::*;
#(
  parameter int W = 40
) (
  input  logic [7:0]   crcIn,
  input  logic [W-1:0] data,
  output logic [7:0]   crcOut
);

  logic [7:0] c;
  logic       fb;

  // Bit-serial LFSR unrolled across the whole word, first bit is data[W-1].
  always_comb begin
    c  = crcIn;
    fb = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      fb = c[7] ^ data[i];
      c  = {c[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
    end
    crcOut = c;
  end

endmodule
`endif

// File: rtl/etroc2_frame_parser.sv
// ETROC2 frame-word parser feeding the pixel data checker, with frame-integrity counters.
// Optional running CRC-8 check is enabled by defining ETROC2_FRAME_CRC_EN.
module etroc2_frame_parser
  import etroc2_frame_pkg::*;
#(
  parameter logic [16:0] CHIP_ID = 17'h1_5A5A,
  parameter int          CNT_W   = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [39:0]      wordIn,
  input  logic             wordValid,
  output logic             hit,
  output logic             eventStart,
  output logic [28:0]      TDCData,
  output logic [7:0]       pixelID,
  output logic [11:0]      BCID,
  output logic             inFrame,
  output logic [CNT_W-1:0] frameCount,
  output logic [CNT_W-1:0] frameErrorCount,
  output logic [CNT_W-1:0] hitCountErrorCount,
  output logic [CNT_W-1:0] l1GapCount
`ifdef ETROC2_FRAME_CRC_EN
  ,
  output logic [CNT_W-1:0] crcErrorCount
`endif
);

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  frame_state_t state, stateNext;

  logic       isHeader, isFiller, isData, isTrailer, isIllegal;
  logic       acceptHeader, acceptData, acceptTrailer, protoErr;
  logic       hitNext, startNext, hitsMismatch;
  logic       startSent, l1Seeded;
  logic [7:0] hitCnt, prevL1, hdrL1;

  assign isHeader  = (wordIn[MARK_HI:MARK_LO] == HEADER_MARK) && (wordIn[TYPE_HI:TYPE_LO] == HDR_TYPE);
  assign isFiller  = (wordIn[MARK_HI:MARK_LO] == HEADER_MARK) && (wordIn[TYPE_HI:TYPE_LO] == FILLER_TYPE);
  assign isData    = wordIn[MARK_HI];
  assign isTrailer = !wordIn[MARK_HI] && (wordIn[CHIP_HI:CHIP_LO] == CHIP_ID);
  assign isIllegal = !(isHeader || isFiller || isData || isTrailer);
  assign hdrL1     = wordIn[L1_HI:L1_LO];
  assign inFrame   = (state == IN_FRAME);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:     if (wordValid && isHeader)  stateNext = IN_FRAME;
      IN_FRAME: if (wordValid && isTrailer) stateNext = IDLE;
      default:  stateNext = IDLE;
    endcase
  end

  // A header is always taken (restarting any open frame); data/trailer only inside a frame.
  always_comb begin
    acceptHeader  = 1'b0;
    acceptData    = 1'b0;
    acceptTrailer = 1'b0;
    protoErr      = 1'b0;
    if (wordValid) begin
      if (isIllegal) begin
        protoErr = 1'b1;
      end else if (isHeader) begin
        acceptHeader = 1'b1;
        protoErr     = (state == IN_FRAME);
      end else if (isData) begin
        acceptData = (state == IN_FRAME);
        protoErr   = (state == IDLE);
      end else if (isTrailer) begin
        acceptTrailer = (state == IN_FRAME);
        protoErr      = (state == IDLE);
      end
    end
    hitNext      = acceptData;
    startNext    = (acceptData || acceptTrailer) && !startSent;
    hitsMismatch = acceptTrailer && (wordIn[HITS_HI:HITS_LO] != hitCnt);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hit                <= 1'b0;
      eventStart         <= 1'b0;
      TDCData            <= '0;
      pixelID            <= '0;
      BCID               <= '0;
      frameCount         <= '0;
      frameErrorCount    <= '0;
      hitCountErrorCount <= '0;
      l1GapCount         <= '0;
      hitCnt             <= '0;
      startSent          <= 1'b0;
      prevL1             <= '0;
      l1Seeded           <= 1'b0;
    end else begin
      hit        <= hitNext;
      eventStart <= startNext;
      if (acceptHeader) begin
        BCID      <= wordIn[BCID_HI:BCID_LO];
        hitCnt    <= '0;
        startSent <= 1'b0;
        prevL1    <= hdrL1;
        l1Seeded  <= 1'b1;
        if (l1Seeded && (hdrL1 != prevL1 + 8'd1)) l1GapCount <= satInc(l1GapCount);
      end
      if (acceptData) begin
        TDCData   <= wordIn[TDC_HI:TDC_LO];
        pixelID   <= wordIn[PIX_HI:PIX_LO];
        startSent <= 1'b1;
        if (hitCnt != 8'hFF) hitCnt <= hitCnt + 8'd1;
      end
      if (acceptTrailer) frameCount <= satInc(frameCount);
      if (hitsMismatch)  hitCountErrorCount <= satInc(hitCountErrorCount);
      if (protoErr)      frameErrorCount <= satInc(frameErrorCount);
    end
  end

`ifdef ETROC2_FRAME_CRC_EN
  logic [7:0] crcReg, crcWord, crcTrail;

  etroc2_crc8_40b #(.W(40)) uCrcWord (
    .crcIn  (acceptHeader ? 8'h00 : crcReg),
    .data   (wordIn),
    .crcOut (crcWord)
  );

  etroc2_crc8_40b #(.W(32)) uCrcTrail (
    .crcIn  (crcReg),
    .data   (wordIn[39:8]),
    .crcOut (crcTrail)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      crcReg        <= '0;
      crcErrorCount <= '0;
    end else begin
      if (acceptHeader || acceptData) crcReg <= crcWord;
      if (acceptTrailer && (crcTrail != wordIn[CRC_HI:CRC_LO])) crcErrorCount <= satInc(crcErrorCount);
    end
  end
`endif

endmodule
